// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU, {HI=remainder, LO=quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the DIV iterations.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_sign,
    input  logic                  annul,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   result
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem, quo, dvs, dvd_raw;
    logic                sign_q, sign_r, dvs_zero;

    logic                accept, b_zero, last;
    logic [DATA_W:0]     shifted;
    logic [DATA_W-1:0]   diff, rem_nxt, quo_nxt, rem_fix, quo_fix;
    logic                ge;
    logic [2*DATA_W-1:0] fin_result;

    assign accept = (state == IDLE) && start && !annul;
    assign b_zero = (b == '0);
    assign last   = (cnt == CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                state_nxt = b_zero ? DONE : DIV;
`else
                state_nxt = DIV;
`endif
            end
            DIV:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul) state_nxt = IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = accept || (state == DIV);
        ready = (state == DONE);
    end

    // One restoring step: the shifted partial remainder is DATA_W+1 bits wide,
    // but whenever the subtraction succeeds the difference fits in DATA_W bits.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        ge      = (shifted >= {1'b0, dvs});
        diff    = shifted[DATA_W-1:0] - dvs;
        rem_nxt = ge ? diff : shifted[DATA_W-1:0];
        quo_nxt = {quo[DATA_W-2:0], ge};
        rem_fix = sign_r ? -rem_nxt : rem_nxt;
        quo_fix = sign_q ? -quo_nxt : quo_nxt;
        fin_result = dvs_zero ? {dvd_raw, {DATA_W{1'b1}}} : {rem_fix, quo_fix};
    end

    // Result is written on the edge entering DONE so it is valid alongside ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dvd_raw  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvs_zero <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= (is_sign && a[DATA_W-1]) ? -a : a;
            dvs      <= (is_sign && b[DATA_W-1]) ? -b : b;
            dvd_raw  <= a;
            sign_q   <= is_sign && (a[DATA_W-1] ^ b[DATA_W-1]);
            sign_r   <= is_sign && a[DATA_W-1];
            dvs_zero <= b_zero;
`ifdef DIV_ZERO_FAST_EN
            if (b_zero) result <= {a, {DATA_W{1'b1}}};
`endif
        end else if (state == DIV && !annul) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (last) result <= fin_result;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: values, latency, busy/ready timing, annul and reset.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero latency.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst, start, is_sign, annul;
    logic [31:0] a, b;
    logic        busy, ready;
    logic [63:0] result;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_iter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_sign(is_sign), .annul(annul),
        .a(a), .b(b), .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle 0 is the cycle start is presented; operands are scrambled afterwards.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] va,
                           input logic [31:0] vb, input logic [63:0] exp, input int lat,
                           input bit hold);
        int k;
        bit busy_ok, seen;
        @(negedge clk);
        start = 1'b1; is_sign = sgn; a = va; b = vb;
        #1;
        chk({tag, "/busy_c0"}, 64'(busy), 64'd1);
        busy_ok = 1'b1; seen = 1'b0; k = 0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (!hold) start = 1'b0;
            a = ~va ^ 32'(k); b = vb + 32'(k) + 32'd1; is_sign = ~sgn;
            #1;
            if (ready) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(k), 64'(lat));
        chk({tag, "/busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "/result"}, result, exp);
        chk({tag, "/busy_done"}, 64'(busy), 64'd0);
        @(negedge clk); #1;
        chk({tag, "/ready_pulse"}, 64'(ready), 64'd0);
        chk({tag, "/busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        bit          rdy_seen;
        rst = 1'b1; start = 1'b0; is_sign = 1'b0; annul = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/ready", 64'(ready), 64'd0);
        chk("rst/result", result, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,        {32'd2, 32'd14}, 33, 1'b0);
        run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0);
        run_div("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0, 32'hFFFF_FFFF}, 33, 1'b0);
        run_div("divu_max_10",  1'b0, 32'hFFFF_FFFF,  32'd10,       {32'd5, 32'h1999_9999}, 33, 1'b0);
        run_div("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 1'b0);
        run_div("divu_by0",     1'b0, 32'h0000_1234,  32'd0,        {32'h0000_1234, 32'hFFFF_FFFF}, ZLAT, 1'b0);
        run_div("div_m5_by0",   1'b1, 32'hFFFF_FFFB,  32'd0,        {32'hFFFF_FFFB, 32'hFFFF_FFFF}, ZLAT, 1'b0);

        // Annul in the middle of a division.
        prev = {32'hFFFF_FFFB, 32'hFFFF_FFFF};
        @(negedge clk);
        start = 1'b1; is_sign = 1'b0; a = 32'd100; b = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 10) annul = 1'b1;
        end
        @(negedge clk); annul = 1'b0; #1;
        chk("annul/busy_c11", 64'(busy), 64'd0);
        rdy_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (ready) rdy_seen = 1'b1;
        end
        chk("annul/no_ready", 64'(rdy_seen), 64'd0);
        chk("annul/result_kept", result, prev);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

        // start with annul in the same cycle is not accepted.
        @(negedge clk);
        start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5; #1;
        chk("st_annul/busy_c0", 64'(busy), 64'd0);
        @(negedge clk); start = 1'b0; annul = 1'b0; #1;
        chk("st_annul/busy_c1", 64'(busy), 64'd0);

        // start held high with changing operands.
        run_div("hold_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; is_sign = 1'b0; a = 32'd50; b = 32'd5;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 20) rst = 1'b1;
        end
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid/busy", 64'(busy), 64'd0);
        chk("rst_mid/ready", 64'(ready), 64'd0);
        chk("rst_mid/result", result, 64'd0);
        run_div("post_rst_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
